// File: rtl/ws_strip_arbiter.sv
// ws_strip_arbiter
// Round-robin arbiter and sequencer that shares one ws2812b strip driver
// between NREQ requesters. The winner's colour and LED count are latched and
// handed to the driver with a single-cycle write; the arbiter then waits for
// the frame to finish and holds off for GAP_CYCLES so the strip latches.
//
// Handshakes:
//   requester side: req[i] is a level, held high with stable data until
//     ack[i] pulses for one cycle. Dropping req[i] before grant[i] rises
//     withdraws the request; dropping it after grant has no effect.
//   driver side: drv_write pulses for one cycle with drv_color/drv_nb_led
//     valid; drv_busy is expected to rise within BUSY_TIMEOUT cycles and to
//     fall when the frame is out. A missing busy sets timeout_err (sticky).
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   req          per-requester request level
//   req_color    requester i colour in [24*i+23:24*i], GRB order
//   req_nb_led   requester i LED count in [32*i+31:32*i]
//   ack          one-cycle pulse to the requester whose frame completed
//   grant        one-hot, requester being serviced (ISSUE .. WAIT_DONE)
//   timeout_err  sticky, drv_busy never rose after a write
//   drv_color    colour to driver
//   drv_nb_led   LED count to driver
//   drv_write    single-cycle write strobe to driver
//   drv_busy     driver frame in progress
//
// All outputs are registered, so drv_write appears two cycles after the
// request is sampled in IDLE and the next write is at least GAP_CYCLES+2
// cycles after an ack. GAP_CYCLES and BUSY_TIMEOUT must be at least 1.
module ws_strip_arbiter #(
    parameter int NREQ         = 4,
    parameter int GAP_CYCLES   = 6000,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*24-1:0] req_color,
    input  logic [NREQ*32-1:0] req_nb_led,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    grant,
    output logic               timeout_err,
    output logic [23:0]        drv_color,
    output logic [31:0]        drv_nb_led,
    output logic               drv_write,
    input  logic               drv_busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] last;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand_idx;
    logic [23:0]      win_color;
    logic [31:0]      win_nb_led;
    int               cand;

    logic take;
    logic busy_expired;
    logic frame_done;
    logic gap_done;

    // Round-robin search: first set req bit starting just after the last
    // winner, wrapping modulo NREQ.
    always_comb begin
        win_valid  = 1'b0;
        win_idx    = '0;
        cand       = 0;
        cand_idx   = '0;
        win_color  = '0;
        win_nb_led = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last) + k) % NREQ;
            cand_idx = IDX_W'(cand);
            if (!win_valid && req[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (IDX_W'(k) == win_idx) begin
                win_color  = req_color[24*k +: 24];
                win_nb_led = req_nb_led[32*k +: 32];
            end
        end
    end

    assign take         = (state == IDLE) && win_valid;
    assign busy_expired = (state == WAIT_BUSY) && !drv_busy && (to_cnt == TO_LAST);
    assign frame_done   = (state == WAIT_DONE) && !drv_busy;
    assign gap_done     = (state == GAP) && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (take) state_next = ISSUE;
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (drv_busy) begin
                    state_next = WAIT_DONE;
                end else if (busy_expired) begin
                    state_next = GAP;
                end
            end
            WAIT_DONE: if (frame_done) state_next = GAP;
            GAP:       if (gap_done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack         <= '0;
            grant       <= '0;
            timeout_err <= 1'b0;
            drv_color   <= '0;
            drv_nb_led  <= '0;
            drv_write   <= 1'b0;
            last        <= IDX_W'(NREQ - 1);
            to_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            ack       <= '0;
            // Registered strobe: high for the one cycle following ISSUE.
            drv_write <= (state == ISSUE);

            if (take) begin
                drv_color  <= win_color;
                drv_nb_led <= win_nb_led;
                grant      <= NREQ'(1) << win_idx;
                last       <= win_idx;
            end

            if (state == ISSUE) begin
                to_cnt <= '0;
            end else if ((state == WAIT_BUSY) && !drv_busy && !busy_expired) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (busy_expired) begin
                timeout_err <= 1'b1;
            end

            // A timed-out frame is acked like a finished one so the
            // requester is never left waiting.
            if (busy_expired || frame_done) begin
                ack     <= grant;
                grant   <= '0;
                gap_cnt <= '0;
            end else if ((state == GAP) && !gap_done) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/ws_strip_arbiter.md
Name: ws_strip_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one ws2812b strip driver between NREQ requesters (pattern generators, test logic, UART command path).
- Latches the winning requester's colour and LED count, then issues a single-cycle write to the driver.
- Waits for the frame to finish and enforces a minimum latch gap before the next frame.
- Sits between the user logic and the driver in the top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYCLES, 6000, minimum idle cycles after drv_busy falls before the next write (≥50 µs strip latch time at 100 MHz, plus margin).
- BUSY_TIMEOUT, 255, maximum cycles to wait for drv_busy to rise after a write.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next clk edge).
- req  in  NREQ  per-requester request level; held high with stable data until that requester's ack.
- req_color  in  NREQ*24  requester i colour in bits [24*i+23:24*i], GRB order as the driver expects.
- req_nb_led  in  NREQ*32  requester i LED count in bits [32*i+31:32*i].
- ack  out  NREQ  one-cycle pulse to the requester whose frame completed.
- grant  out  NREQ  one-hot; high for the requester being serviced, from ISSUE through the end of WAIT_DONE.
- timeout_err  out  1  sticky; set when drv_busy fails to rise; cleared only by reset.
- drv_color  out  24  colour to driver.
- drv_nb_led  out  32  LED count to driver.
- drv_write  out  1  single-cycle write strobe to driver.
- drv_busy  in  1  driver frame in progress.

Behaviour:
- Reset (rst=0): state=IDLE; ack=0, grant=0, drv_write=0, drv_color=0, drv_nb_led=0, timeout_err=0; round-robin pointer last=NREQ-1, so requester 0 has first priority. Reset mid-frame aborts immediately; no ack is issued.
- IDLE:
  - If any req bit is set, select the first set bit searching last+1, last+2, … modulo NREQ.
  - Latch that requester's colour and nb_led into drv_color and drv_nb_led. Set grant and last to the winner. Go to ISSUE.
  - Requests are sampled only in IDLE; a later higher-priority request does not pre-empt.
- ISSUE: drv_write=1 for exactly this one cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - drv_busy=1 → WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT, set timeout_err, pulse ack for the granted requester, clear grant, and go to GAP (this prevents a lock-up).
- WAIT_DONE:
  - On the first cycle with drv_busy=0: pulse ack[grant] for one cycle, clear grant, clear the gap counter, go to GAP.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - req is ignored during GAP, so the earliest next drv_write is GAP_CYCLES+2 cycles after ack.
- Special cases:
  - nb_led=0 is passed through unchanged; the driver is expected to raise busy briefly or time out.
  - drv_color and drv_nb_led hold stable from the latch until the next grant.
- Latency: req seen in IDLE → drv_write two cycles later (latch cycle, then ISSUE).
- Fairness: a requester that keeps req asserted is serviced at most once per round while others are pending.
- A requester may deassert req before grant (the request is withdrawn). Deasserting after grant has no effect; the frame completes.
- Counters are sized with $clog2 of their parameter, plus 1 bit.

Test Plan:
- Single request: req=0001, color0=24'h00FF00, nb_led0=2; driver model raises busy 3 cycles after write and holds it 100 cycles → one drv_write pulse with drv_color=00FF00, drv_nb_led=2; ack[0] pulses on the busy falling edge; grant=0001 throughout.
- Round robin: req=1111 held, each requester re-requesting immediately after its ack → grants in the order 0,1,2,3,0; each ack followed by at least GAP_CYCLES idle cycles before the next drv_write.
- Priority rotation: after servicing req 2, assert req=0101 simultaneously → req 0 is granted next (search order 3,0,1).
- Timeout: driver model never raises busy; req=0010 → after BUSY_TIMEOUT cycles timeout_err=1 and ack[1] pulses; the next request is still serviced; timeout_err stays 1.
- Reset mid-frame: rst=0 during WAIT_DONE → next cycle all outputs are 0, with no ack; after rst=1, req=0001 is serviced normally, starting from requester 0.
- Withdrawn request: req[3] pulses high for one cycle while state is GAP → no grant to 3; no drv_write occurs.
